// File: rtl/dma_rd_mc.sv
// Synchronous FIFO: registered storage with count-based full/empty flags.
// Latency: one cycle from push to visible at the head.
// Backpressure: a push into a full FIFO is taken only when a pop happens in the same cycle.
module dma_rd_mc_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push_vld,
  input  logic [WIDTH-1:0] push_dat,
  input  logic             pop_rdy,
  output logic [WIDTH-1:0] pop_dat,
  output logic             full,
  output logic             empty
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PW-1:0]    wr_ptr_q;
  logic [PW-1:0]    rd_ptr_q;
  logic [CW-1:0]    cnt_q;
  logic             do_push;
  logic             do_pop;

  function automatic logic [PW-1:0] inc_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
  endfunction

  assign empty   = (cnt_q == '0);
  assign full    = (cnt_q == CW'(DEPTH));
  assign do_pop  = pop_rdy & ~empty;
  assign do_push = push_vld & (~full | do_pop);
  assign pop_dat = mem_q[rd_ptr_q];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      if (do_push) wr_ptr_q <= inc_ptr(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= inc_ptr(rd_ptr_q);
      if (do_push && !do_pop)      cnt_q <= cnt_q + CW'(1);
      else if (!do_push && do_pop) cnt_q <= cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= push_dat;
  end
endmodule

// Multi-channel DMA read engine: round-robin over per-channel command FIFOs, AR burst split, tagged R stream.
// Latency: command visible at the FIFO head 1 cycle after push, granted that cycle, AR valid the next; R to stream is combinational.
// Backpressure: config_ready drops when a channel FIFO is full; AR stalls on a full tracker; R stalls via downstream ready.
module dma_rd_mc #(
  parameter int NUM_CH            = 2,
  parameter int AXI_DATA_WIDTH    = 32,
  parameter int AXI_ADDR_WIDTH    = 32,
  parameter int AXI_ID_WIDTH      = 8,
  parameter int CONFIG_LEN_WIDTH  = 9,
  parameter int CMD_DEPTH         = 2,
  parameter int OUTSTANDING_COUNT = 4,
  parameter int MAX_BURST         = 16,
  localparam int CH_W             = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [NUM_CH-1:0]                    config_valid,
  output logic [NUM_CH-1:0]                    config_ready,
  input  logic [NUM_CH*AXI_ADDR_WIDTH-1:0]     config_addr,
  input  logic [NUM_CH*CONFIG_LEN_WIDTH-1:0]   config_len,
  output logic [NUM_CH-1:0]                    config_empty,
  output logic [NUM_CH-1:0]                    resp_err,
  output logic [AXI_ID_WIDTH-1:0]              m_axi_arid,
  output logic [AXI_ADDR_WIDTH-1:0]            m_axi_araddr,
  output logic [7:0]                           m_axi_arlen,
  output logic [2:0]                           m_axi_arsize,
  output logic [1:0]                           m_axi_arburst,
  output logic                                 m_axi_arlock,
  output logic [3:0]                           m_axi_arcache,
  output logic [2:0]                           m_axi_arprot,
  output logic                                 m_axi_arvalid,
  input  logic                                 m_axi_arready,
  input  logic [AXI_ID_WIDTH-1:0]              m_axi_rid,
  input  logic [AXI_DATA_WIDTH-1:0]            m_axi_rdata,
  input  logic [1:0]                           m_axi_rresp,
  input  logic                                 m_axi_rlast,
  input  logic                                 m_axi_rvalid,
  output logic                                 m_axi_rready,
  output logic [AXI_DATA_WIDTH-1:0]            data_out,
  output logic [CH_W-1:0]                      dest_out,
  output logic                                 valid_out,
  output logic                                 last_out,
  input  logic                                 ready
);
  localparam int BYTES = AXI_DATA_WIDTH / 8;
  localparam int SZ    = $clog2(BYTES);
  localparam int LW    = ((CONFIG_LEN_WIDTH > 13) ? CONFIG_LEN_WIDTH : 13) + 1;
  localparam int OCW   = $clog2(OUTSTANDING_COUNT + 1);

  typedef struct packed {
    logic [AXI_ADDR_WIDTH-1:0]   addr;
    logic [CONFIG_LEN_WIDTH-1:0] len;
  } cmd_t;

  typedef struct packed {
    logic [CH_W-1:0] ch;
    logic            last;
  } trk_t;

  typedef enum logic {S_IDLE, S_ISSUE} state_t;

  state_t                      state_q, state_d;
  logic [CH_W-1:0]             rr_ptr_q, rr_ptr_d;
  logic [CH_W-1:0]             cur_ch_q, cur_ch_d;
  logic [AXI_ADDR_WIDTH-1:0]   cur_addr_q, cur_addr_d;
  logic [CONFIG_LEN_WIDTH-1:0] rem_q, rem_d;

  cmd_t              cmd_head [NUM_CH];
  logic [NUM_CH-1:0] cmd_full;
  logic [NUM_CH-1:0] cmd_empty;
  logic [NUM_CH-1:0] cmd_pop;

  logic              grant_vld;
  logic [CH_W-1:0]   grant_ch;
  cmd_t              grant_cmd;

  logic [LW-1:0]     to_4k;
  logic [LW-1:0]     beats;
  logic              last_burst;

  trk_t              trk_in;
  trk_t              trk_head;
  logic              trk_full;
  logic              trk_empty;
  logic              trk_pop;
  logic              ar_hs;
  logic              r_hs;
  logic              unused_rid;

  assign unused_rid = ^m_axi_rid;

  // Per-channel command queue, outstanding-burst count and sticky error flag
  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    cmd_t           cmd_in;
    logic [OCW-1:0] out_cnt_q;
    logic           err_q;
    logic           inc;
    logic           dec;

    assign cmd_in.addr     = config_addr[i*AXI_ADDR_WIDTH +: AXI_ADDR_WIDTH] & ~AXI_ADDR_WIDTH'(BYTES - 1);
    assign cmd_in.len      = config_len[i*CONFIG_LEN_WIDTH +: CONFIG_LEN_WIDTH];
    assign config_ready[i] = ~cmd_full[i] | cmd_pop[i];

    dma_rd_mc_fifo #(
      .WIDTH ($bits(cmd_t)),
      .DEPTH (CMD_DEPTH)
    ) u_cmd_fifo (
      .clk      (clk),
      .rst      (rst),
      .push_vld (config_valid[i] & config_ready[i]),
      .push_dat (cmd_in),
      .pop_rdy  (cmd_pop[i]),
      .pop_dat  (cmd_head[i]),
      .full     (cmd_full[i]),
      .empty    (cmd_empty[i])
    );

    assign inc = ar_hs & (cur_ch_q == CH_W'(i));
    assign dec = trk_pop & (trk_head.ch == CH_W'(i));

    always_ff @(posedge clk) begin
      if (rst) begin
        out_cnt_q <= '0;
        err_q     <= 1'b0;
      end else begin
        if (inc && !dec)      out_cnt_q <= out_cnt_q + OCW'(1);
        else if (!inc && dec) out_cnt_q <= out_cnt_q - OCW'(1);
        if (r_hs && (m_axi_rresp != 2'b00) && (trk_head.ch == CH_W'(i))) err_q <= 1'b1;
      end
    end

    assign resp_err[i]     = err_q;
    assign config_empty[i] = cmd_empty[i] & ~((state_q == S_ISSUE) && (cur_ch_q == CH_W'(i)))
                             & (out_cnt_q == '0);
  end

  // Lowest non-empty channel overall, overridden by the lowest one at or after rr_ptr
  always_comb begin
    grant_vld = 1'b0;
    grant_ch  = '0;
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (!cmd_empty[c]) begin
        grant_vld = 1'b1;
        grant_ch  = CH_W'(c);
      end
    end
    for (int c = NUM_CH - 1; c >= 0; c--) begin
      if (!cmd_empty[c] && (CH_W'(c) >= rr_ptr_q)) grant_ch = CH_W'(c);
    end
  end

  assign grant_cmd = cmd_head[grant_ch];

  always_comb begin
    to_4k = (LW'(4096) - LW'(cur_addr_q[11:0])) >> SZ;
    beats = LW'(rem_q);
    if (beats > LW'(MAX_BURST)) beats = LW'(MAX_BURST);
    if (beats > to_4k)          beats = to_4k;
  end

  assign last_burst = (LW'(rem_q) == beats);

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE:  if (grant_vld && (grant_cmd.len != '0)) state_d = S_ISSUE;
      S_ISSUE: if (ar_hs && last_burst) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    cmd_pop       = '0;
    m_axi_arvalid = 1'b0;
    m_axi_araddr  = cur_addr_q;
    m_axi_arlen   = 8'(beats - LW'(1));
    m_axi_arid    = AXI_ID_WIDTH'(cur_ch_q);
    m_axi_arsize  = 3'(SZ);
    m_axi_arburst = 2'b01;
    m_axi_arlock  = 1'b0;
    m_axi_arcache = 4'b0011;
    m_axi_arprot  = 3'b000;
    if (state_q == S_IDLE && grant_vld) cmd_pop[grant_ch] = 1'b1;
    // Tracker only fills through AR handshakes, so arvalid cannot drop before one
    if (state_q == S_ISSUE) m_axi_arvalid = ~trk_full;
  end

  always_comb begin
    rr_ptr_d   = rr_ptr_q;
    cur_ch_d   = cur_ch_q;
    cur_addr_d = cur_addr_q;
    rem_d      = rem_q;
    if (state_q == S_IDLE && grant_vld) begin
      cur_ch_d   = grant_ch;
      cur_addr_d = grant_cmd.addr;
      rem_d      = grant_cmd.len;
      rr_ptr_d   = (grant_ch == CH_W'(NUM_CH - 1)) ? '0 : grant_ch + CH_W'(1);
    end else if (ar_hs) begin
      cur_addr_d = cur_addr_q + (AXI_ADDR_WIDTH'(beats) << SZ);
      rem_d      = rem_q - CONFIG_LEN_WIDTH'(beats);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr_q   <= '0;
      cur_ch_q   <= '0;
      cur_addr_q <= '0;
      rem_q      <= '0;
    end else begin
      rr_ptr_q   <= rr_ptr_d;
      cur_ch_q   <= cur_ch_d;
      cur_addr_q <= cur_addr_d;
      rem_q      <= rem_d;
    end
  end

  assign ar_hs   = m_axi_arvalid & m_axi_arready;
  assign r_hs    = m_axi_rvalid & m_axi_rready;
  assign trk_pop = r_hs & m_axi_rlast;
  assign trk_in  = '{ch: cur_ch_q, last: last_burst};

  dma_rd_mc_fifo #(
    .WIDTH ($bits(trk_t)),
    .DEPTH (OUTSTANDING_COUNT)
  ) u_trk_fifo (
    .clk      (clk),
    .rst      (rst),
    .push_vld (ar_hs),
    .push_dat (trk_in),
    .pop_rdy  (trk_pop),
    .pop_dat  (trk_head),
    .full     (trk_full),
    .empty    (trk_empty)
  );

  assign data_out     = m_axi_rdata;
  assign dest_out     = trk_head.ch;
  assign valid_out    = m_axi_rvalid & ~trk_empty;
  assign m_axi_rready = ready & ~trk_empty;
  assign last_out     = valid_out & m_axi_rlast & trk_head.last;
endmodule

// File: tb/tb_dma_rd_mc.sv
// Directed bench for dma_rd_mc: table of single-command burst splits, then round-robin,
// outstanding limit, config backpressure/zero length and error/reset sequences.
module tb_dma_rd_mc;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  config_valid = '0;
  logic [1:0]  config_ready;
  logic [63:0] config_addr = '0;
  logic [17:0] config_len = '0;
  logic [1:0]  config_empty;
  logic [1:0]  resp_err;
  logic [7:0]  m_axi_arid;
  logic [31:0] m_axi_araddr;
  logic [7:0]  m_axi_arlen;
  logic [2:0]  m_axi_arsize;
  logic [1:0]  m_axi_arburst;
  logic        m_axi_arlock;
  logic [3:0]  m_axi_arcache;
  logic [2:0]  m_axi_arprot;
  logic        m_axi_arvalid;
  logic        m_axi_arready = 1'b0;
  logic [7:0]  m_axi_rid = '0;
  logic [31:0] m_axi_rdata = '0;
  logic [1:0]  m_axi_rresp = '0;
  logic        m_axi_rlast = 1'b0;
  logic        m_axi_rvalid = 1'b0;
  logic        m_axi_rready;
  logic [31:0] data_out;
  logic [0:0]  dest_out;
  logic        valid_out;
  logic        last_out;
  logic        ready = 1'b1;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [0:0]  ch;
    logic [31:0] addr;
    logic [8:0]  len;
    logic [1:0]  nb;
    logic [31:0] a0;
    logic [7:0]  l0;
    logic [31:0] a1;
    logic [7:0]  l1;
    logic [31:0] a2;
    logic [7:0]  l2;
  } vec_t;

  vec_t vecs [6];

  dma_rd_mc dut (
    .clk           (clk),
    .rst           (rst),
    .config_valid  (config_valid),
    .config_ready  (config_ready),
    .config_addr   (config_addr),
    .config_len    (config_len),
    .config_empty  (config_empty),
    .resp_err      (resp_err),
    .m_axi_arid    (m_axi_arid),
    .m_axi_araddr  (m_axi_araddr),
    .m_axi_arlen   (m_axi_arlen),
    .m_axi_arsize  (m_axi_arsize),
    .m_axi_arburst (m_axi_arburst),
    .m_axi_arlock  (m_axi_arlock),
    .m_axi_arcache (m_axi_arcache),
    .m_axi_arprot  (m_axi_arprot),
    .m_axi_arvalid (m_axi_arvalid),
    .m_axi_arready (m_axi_arready),
    .m_axi_rid     (m_axi_rid),
    .m_axi_rdata   (m_axi_rdata),
    .m_axi_rresp   (m_axi_rresp),
    .m_axi_rlast   (m_axi_rlast),
    .m_axi_rvalid  (m_axi_rvalid),
    .m_axi_rready  (m_axi_rready),
    .data_out      (data_out),
    .dest_out      (dest_out),
    .valid_out     (valid_out),
    .last_out      (last_out),
    .ready         (ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic push_cmd(input int ch, input logic [31:0] a, input logic [8:0] l);
    int n = 0;
    config_valid[ch] = 1'b1;
    config_addr[ch*32 +: 32] = a;
    config_len[ch*9 +: 9] = l;
    #1;
    while (!config_ready[ch] && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("push_ready", 64'(config_ready[ch]), 64'd1);
    @(negedge clk);
    config_valid[ch] = 1'b0;
  endtask

  task automatic expect_ar(input logic [31:0] a, input logic [7:0] l, input logic [7:0] id);
    int n = 0;
    #1;
    while (!m_axi_arvalid && n < 100) begin
      @(negedge clk);
      #1;
      n++;
    end
    check("arvalid", 64'(m_axi_arvalid), 64'd1);
    check("araddr", 64'(m_axi_araddr), 64'(a));
    check("arlen", 64'(m_axi_arlen), 64'(l));
    check("arid", 64'(m_axi_arid), 64'(id));
    check("arsize_burst_cache", 64'({m_axi_arsize, m_axi_arburst, m_axi_arcache, m_axi_arlock, m_axi_arprot}),
          64'({3'd2, 2'b01, 4'b0011, 1'b0, 3'b000}));
    m_axi_arready = 1'b1;
    @(negedge clk);
    m_axi_arready = 1'b0;
  endtask

  task automatic send_beats(input int n, input int ch, input bit burst_end, input bit cmd_end, input int err_idx);
    logic [31:0] d;
    for (int b = 0; b < n; b++) begin
      d = 32'hA500_0000 + 32'(ch * 4096) + 32'(b);
      m_axi_rvalid = 1'b1;
      m_axi_rdata  = d;
      m_axi_rlast  = burst_end && (b == n - 1);
      m_axi_rresp  = (b == err_idx) ? 2'd2 : 2'd0;
      #1;
      check("valid_out", 64'(valid_out), 64'd1);
      check("rready", 64'(m_axi_rready), 64'd1);
      check("dest_out", 64'(dest_out), 64'(ch));
      check("last_out", 64'(last_out), 64'(cmd_end && burst_end && (b == n - 1)));
      check("data_out", 64'(data_out), 64'(d));
      @(negedge clk);
    end
    m_axi_rvalid = 1'b0;
    m_axi_rlast  = 1'b0;
    m_axi_rresp  = 2'd0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] ea [3];
    logic [7:0]  el [3];
    int nb;
    int hs;

    vecs[0] = '{ch: 1'b0, addr: 32'h1000, len: 9'd20, nb: 2'd2,
                a0: 32'h1000, l0: 8'd15, a1: 32'h1040, l1: 8'd3, a2: 32'h0, l2: 8'd0};
    vecs[1] = '{ch: 1'b0, addr: 32'h0FF8, len: 9'd4, nb: 2'd2,
                a0: 32'h0FF8, l0: 8'd1, a1: 32'h1000, l1: 8'd1, a2: 32'h0, l2: 8'd0};
    vecs[2] = '{ch: 1'b1, addr: 32'h2003, len: 9'd1, nb: 2'd1,
                a0: 32'h2000, l0: 8'd0, a1: 32'h0, l1: 8'd0, a2: 32'h0, l2: 8'd0};
    vecs[3] = '{ch: 1'b1, addr: 32'h0FC0, len: 9'd40, nb: 2'd3,
                a0: 32'h0FC0, l0: 8'd15, a1: 32'h1000, l1: 8'd15, a2: 32'h1040, l2: 8'd7};
    vecs[4] = '{ch: 1'b0, addr: 32'h3FFC, len: 9'd2, nb: 2'd2,
                a0: 32'h3FFC, l0: 8'd0, a1: 32'h4000, l1: 8'd0, a2: 32'h0, l2: 8'd0};
    vecs[5] = '{ch: 1'b1, addr: 32'h5000, len: 9'd16, nb: 2'd1,
                a0: 32'h5000, l0: 8'd15, a1: 32'h0, l1: 8'd0, a2: 32'h0, l2: 8'd0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst_valid_last", 64'({valid_out, last_out}), 64'd0);
    check("rst_resp_err", 64'(resp_err), 64'd0);
    check("rst_cfg_ready", 64'(config_ready), 64'd3);
    check("rst_cfg_empty", 64'(config_empty), 64'd3);
    check("rst_rready", 64'(m_axi_rready), 64'd0);

    for (int v = 0; v < 6; v++) begin
      ea[0] = vecs[v].a0; el[0] = vecs[v].l0;
      ea[1] = vecs[v].a1; el[1] = vecs[v].l1;
      ea[2] = vecs[v].a2; el[2] = vecs[v].l2;
      nb = int'(vecs[v].nb);
      push_cmd(int'(vecs[v].ch), vecs[v].addr, vecs[v].len);
      for (int k = 0; k < nb; k++) expect_ar(ea[k], el[k], 8'(vecs[v].ch));
      for (int k = 0; k < nb; k++) send_beats(int'(el[k]) + 1, int'(vecs[v].ch), 1'b1, k == nb - 1, -1);
      #1;
      check("vec_cfg_empty", 64'(config_empty), 64'd3);
    end

    // Round robin: a ch0 blocker holds the FSM in ISSUE while both queues fill
    push_cmd(0, 32'h100, 9'd1);
    push_cmd(0, 32'h200, 9'd1);
    push_cmd(0, 32'h300, 9'd1);
    push_cmd(1, 32'h400, 9'd1);
    push_cmd(1, 32'h500, 9'd1);
    expect_ar(32'h100, 8'd0, 8'd0); send_beats(1, 0, 1'b1, 1'b1, -1);
    expect_ar(32'h400, 8'd0, 8'd1); send_beats(1, 1, 1'b1, 1'b1, -1);
    expect_ar(32'h200, 8'd0, 8'd0); send_beats(1, 0, 1'b1, 1'b1, -1);
    expect_ar(32'h500, 8'd0, 8'd1); send_beats(1, 1, 1'b1, 1'b1, -1);
    expect_ar(32'h300, 8'd0, 8'd0); send_beats(1, 0, 1'b1, 1'b1, -1);
    #1;
    check("rr_cfg_empty", 64'(config_empty), 64'd3);

    // Outstanding limit: 5 bursts, R withheld, only 4 AR handshakes fit
    push_cmd(0, 32'h0, 9'd80);
    hs = 0;
    m_axi_arready = 1'b1;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (m_axi_arvalid) hs++;
      @(negedge clk);
    end
    m_axi_arready = 1'b0;
    check("outstanding_hs", 64'(hs), 64'd4);
    #1;
    check("outstanding_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("outstanding_cfg_empty0", 64'(config_empty[0]), 64'd0);
    send_beats(16, 0, 1'b1, 1'b0, -1);
    expect_ar(32'h100, 8'd15, 8'd0);
    send_beats(16, 0, 1'b1, 1'b0, -1);
    send_beats(16, 0, 1'b1, 1'b0, -1);
    send_beats(16, 0, 1'b1, 1'b0, -1);
    send_beats(16, 0, 1'b1, 1'b1, -1);
    #1;
    check("outstanding_cfg_empty", 64'(config_empty), 64'd3);

    // Config backpressure and zero-length drop
    push_cmd(0, 32'h600, 9'd1);
    push_cmd(1, 32'h0, 9'd0);
    push_cmd(1, 32'h700, 9'd1);
    #1;
    check("bp_ready_full", 64'(config_ready[1]), 64'd0);
    check("bp_cfg_empty1", 64'(config_empty[1]), 64'd0);
    config_valid[1] = 1'b1;
    config_addr[32 +: 32] = 32'h780;
    config_len[9 +: 9] = 9'd0;
    repeat (3) @(negedge clk);
    #1;
    check("bp_ready_held", 64'(config_ready[1]), 64'd0);
    expect_ar(32'h600, 8'd0, 8'd0);
    #1;
    check("bp_ready_on_pop", 64'(config_ready[1]), 64'd1);
    @(negedge clk);
    config_valid[1] = 1'b0;
    send_beats(1, 0, 1'b1, 1'b1, -1);
    expect_ar(32'h700, 8'd0, 8'd1);
    send_beats(1, 1, 1'b1, 1'b1, -1);
    repeat (5) @(negedge clk);
    #1;
    check("zlen_no_ar", 64'(m_axi_arvalid), 64'd0);
    check("zlen_cfg_empty", 64'(config_empty), 64'd3);
    check("zlen_no_beat", 64'(valid_out), 64'd0);

    // Error flag, downstream stall, then reset mid-burst
    push_cmd(1, 32'h800, 9'd3);
    expect_ar(32'h800, 8'd2, 8'd1);
    send_beats(3, 1, 1'b1, 1'b1, 1);
    #1;
    check("resp_err_set", 64'(resp_err), 64'd2);
    push_cmd(0, 32'h900, 9'd20);
    expect_ar(32'h900, 8'd15, 8'd0);
    m_axi_rvalid = 1'b1;
    ready = 1'b0;
    #1;
    check("stall_rready", 64'(m_axi_rready), 64'd0);
    check("stall_valid_out", 64'(valid_out), 64'd1);
    ready = 1'b1;
    m_axi_rvalid = 1'b0;
    send_beats(2, 0, 1'b0, 1'b0, -1);
    #1;
    check("mid_arvalid", 64'(m_axi_arvalid), 64'd1);
    check("mid_araddr", 64'(m_axi_araddr), 64'h940);
    check("resp_err_sticky", 64'(resp_err), 64'd2);
    check("mid_cfg_empty0", 64'(config_empty[0]), 64'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("rst2_arvalid", 64'(m_axi_arvalid), 64'd0);
    check("rst2_cfg_empty", 64'(config_empty), 64'd3);
    check("rst2_cfg_ready", 64'(config_ready), 64'd3);
    check("rst2_resp_err", 64'(resp_err), 64'd0);
    check("rst2_valid_last", 64'({valid_out, last_out}), 64'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
